// File: rtl/jtframe_sdram64_mux.sv
// jtframe_sdram64_mux: round-robin sharing of one SDRAM bank port with per-client burst buffers and one-entry read caches
module jtframe_sdram64_mux #(
  parameter int AW    = 22,
  parameter int N     = 4,
  parameter int BURST = 4,
  parameter int CACHE = 1
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic [N-1:0]            c_cs,
  input  logic [N*AW-1:0]         c_addr,
  input  logic [N-1:0]            c_wr,
  input  logic [N*16-1:0]         c_din,
  input  logic [N*2-1:0]          c_din_m,
  output logic [N*16*BURST-1:0]   c_dout,
  output logic [N-1:0]            c_ok,
  output logic [AW-1:0]           ba_addr,
  output logic                    ba_rd,
  output logic                    ba_wr,
  output logic [15:0]             ba_din,
  output logic [1:0]              ba_din_m,
  input  logic                    ba_ack,
  input  logic                    ba_dst,
  input  logic                    ba_dok,
  input  logic                    ba_rdy,
  input  logic [15:0]             ba_dout
);
  localparam int LB = $clog2(BURST);
  localparam int TW = AW - LB;
  localparam int SW = $clog2(N);
  localparam int CW = LB > 0 ? LB : 1;
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t st_q;
  logic [SW-1:0] ptr_q, sel_q, gsel;
  logic [CW-1:0] cnt_q, widx;
  logic wr_q, gnt, gwr;
  logic [N-1:0] valid_q, ok_q, pend, hit, cand;
  logic [TW-1:0] tag_q [N];
  logic [N*16*BURST-1:0] dout_q;
  logic [AW-1:0] addr_q, gaddr;
  logic [TW-1:0] gtag;
  logic rd_q, bwr_q;
  logic [15:0] din_q;
  logic [1:0] dinm_q;
  assign c_dout   = dout_q;
  assign c_ok     = ok_q;
  assign ba_addr  = addr_q;
  assign ba_rd    = rd_q;
  assign ba_wr    = bwr_q;
  assign ba_din   = din_q;
  assign ba_din_m = dinm_q;
  assign gaddr    = c_addr[gsel*AW +: AW];
  assign gwr      = c_wr[gsel];
  assign gtag     = gaddr[LB +: TW];
  assign widx     = (BURST == 1 || ba_dst) ? '0 : cnt_q;
  // pending/hit detection for every client and round-robin pick starting at the pointer
  always_comb begin
    pend = '0;
    hit  = '0;
    gnt  = 1'b0;
    gsel = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = c_cs[i] & ~ok_q[i] & ~(st_q != IDLE && sel_q == SW'(i));
      hit[i]  = CACHE != 0 && st_q == IDLE && pend[i] && !c_wr[i] && valid_q[i]
                && c_addr[i*AW+LB +: TW] == tag_q[i];
    end
    cand = st_q == IDLE ? pend & ~hit : '0;
    for (int k = N-1; k >= 0; k--) begin
      if (cand[(int'(ptr_q)+k) % N]) begin
        gnt  = 1'b1;
        gsel = SW'((int'(ptr_q)+k) % N);
      end
    end
  end
  // arbitration FSM: grant, hold the bank request until ack, then collect burst words until rdy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      valid_q <= '0;
      ok_q    <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      bwr_q   <= 1'b0;
      din_q   <= '0;
      dinm_q  <= '0;
      for (int j = 0; j < N; j++) tag_q[j] <= '0;
    end else begin
      ok_q <= (ok_q & c_cs) | hit;
      case (st_q)
        IDLE: if (gnt) begin
          sel_q  <= gsel;
          ptr_q  <= int'(gsel) == N-1 ? '0 : gsel + 1'b1;
          wr_q   <= gwr;
          rd_q   <= ~gwr;
          bwr_q  <= gwr;
          addr_q <= gwr ? gaddr : gaddr & ~AW'(BURST-1);
          din_q  <= c_din[gsel*16 +: 16];
          dinm_q <= c_din_m[gsel*2 +: 2];
          cnt_q  <= '0;
          st_q   <= REQ;
          for (int j = 0; j < N; j++) if (gwr && tag_q[j] == gtag) valid_q[j] <= 1'b0;
        end
        REQ: if (ba_ack) begin
          rd_q  <= 1'b0;
          bwr_q <= 1'b0;
          st_q  <= DATA;
        end
        DATA: begin
          if (ba_dok && !wr_q) begin
            dout_q[(int'(sel_q)*BURST + int'(widx))*16 +: 16] <= ba_dout;
            cnt_q <= widx + 1'b1;
          end
          if (ba_rdy) begin
            ok_q[sel_q] <= 1'b1;
            st_q        <= IDLE;
            if (!wr_q) begin
              tag_q[sel_q]   <= addr_q[LB +: TW];
              valid_q[sel_q] <= 1'b1;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_sdram64_mux.sv
// tb_jtframe_sdram64_mux: directed vectors and corner-case sequences for the SDRAM bank mux
module tb_jtframe_sdram64_mux;
  localparam int AW = 22, N = 4, BURST = 4;
  logic rst = 1'b1, clk = 1'b0;
  logic [N-1:0] c_cs = '0, c_wr = '0, c_ok;
  logic [N*AW-1:0] c_addr = '0;
  logic [N*16-1:0] c_din = '0;
  logic [N*2-1:0] c_din_m = '0;
  logic [N*16*BURST-1:0] c_dout;
  logic [AW-1:0] ba_addr;
  logic ba_rd, ba_wr, ba_ack = 0, ba_dst = 0, ba_dok = 0, ba_rdy = 0;
  logic [15:0] ba_din, ba_dout = '0;
  logic [1:0] ba_din_m;
  int checks = 0, errors = 0;

  jtframe_sdram64_mux #(.AW(AW), .N(N), .BURST(BURST), .CACHE(1)) dut (
    .rst(rst), .clk(clk), .c_cs(c_cs), .c_addr(c_addr), .c_wr(c_wr), .c_din(c_din),
    .c_din_m(c_din_m), .c_dout(c_dout), .c_ok(c_ok), .ba_addr(ba_addr), .ba_rd(ba_rd),
    .ba_wr(ba_wr), .ba_din(ba_din), .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_dst(ba_dst),
    .ba_dok(ba_dok), .ba_rdy(ba_rdy), .ba_dout(ba_dout));

  always #5 clk = ~clk;

  typedef struct {
    int c; logic wr; logic hit; logic [AW-1:0] addr; logic [15:0] din; logic [1:0] m;
    logic [AW-1:0] ea; logic [63:0] data;
  } vec_t;
  vec_t v[11];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic req(input int c, input logic wr, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    c_cs[c] = 1'b1;
    c_wr[c] = wr;
    c_addr[c*AW +: AW] = a;
    c_din[c*16 +: 16] = d;
    c_din_m[c*2 +: 2] = m;
  endtask

  // acts as the bank: waits for a request, checks it, acks after dly cycles, streams a burst, signals rdy
  task automatic serve(input string nm, input logic [AW-1:0] ea, input logic ew, input logic [15:0] ed,
                       input logic [1:0] em, input int dly, input logic [63:0] data);
    int w = 0;
    while (!(ba_rd | ba_wr) && w < 20) begin tick(); w++; end
    chk({nm, "_req"}, 64'(ba_rd | ba_wr), 64'd1);
    chk({nm, "_addr"}, 64'(ba_addr), 64'(ea));
    chk({nm, "_rdwr"}, 64'({ba_rd, ba_wr}), 64'({~ew, ew}));
    if (ew) chk({nm, "_wdata"}, 64'({ba_din, ba_din_m}), 64'({ed, em}));
    for (int d = 0; d < dly; d++) begin
      tick();
      chk($sformatf("%s_hold%0d", nm, d), 64'({ba_rd, ba_wr, ba_addr}), 64'({~ew, ew, ea}));
    end
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
    chk({nm, "_drop"}, 64'(ba_rd | ba_wr), 64'd0);
    if (!ew) begin
      for (int k = 0; k < BURST; k++) begin
        ba_dok = 1'b1;
        ba_dst = k == 0;
        ba_dout = data[k*16 +: 16];
        tick();
      end
      ba_dok = 1'b0;
      ba_dst = 1'b0;
    end
    ba_rdy = 1'b1;
    tick();
    ba_rdy = 1'b0;
  endtask

  initial begin
    v[0]  = '{0, 1'b0, 1'b0, 22'h000104, 16'h0, 2'b00, 22'h000104, 64'h4444_3333_2222_1111};
    v[1]  = '{0, 1'b0, 1'b1, 22'h000106, 16'h0, 2'b00, 22'h000104, 64'h4444_3333_2222_1111};
    v[2]  = '{1, 1'b0, 1'b0, 22'h000107, 16'h0, 2'b00, 22'h000104, 64'haaaa_bbbb_cccc_dddd};
    v[3]  = '{0, 1'b0, 1'b0, 22'h000100, 16'h0, 2'b00, 22'h000100, 64'h0101_0202_0303_0404};
    v[4]  = '{2, 1'b1, 1'b0, 22'h000102, 16'h1234, 2'b01, 22'h000102, 64'h0};
    v[5]  = '{0, 1'b0, 1'b0, 22'h000100, 16'h0, 2'b00, 22'h000100, 64'h5555_6666_7777_8888};
    v[6]  = '{1, 1'b0, 1'b1, 22'h000105, 16'h0, 2'b00, 22'h000104, 64'haaaa_bbbb_cccc_dddd};
    v[7]  = '{3, 1'b1, 1'b0, 22'h000105, 16'hbeef, 2'b10, 22'h000105, 64'h0};
    v[8]  = '{1, 1'b0, 1'b0, 22'h000104, 16'h0, 2'b00, 22'h000104, 64'h9999_8888_7777_6666};
    v[9]  = '{2, 1'b0, 1'b0, 22'h3fffff, 16'h0, 2'b00, 22'h3ffffc, 64'hdead_beef_cafe_f00d};
    v[10] = '{2, 1'b0, 1'b1, 22'h3ffffd, 16'h0, 2'b00, 22'h3ffffc, 64'hdead_beef_cafe_f00d};
    tick();
    tick();
    chk("rst_ok", 64'(c_ok), 64'd0);
    chk("rst_bank", 64'({ba_rd, ba_wr, ba_addr, ba_din, ba_din_m}), 64'd0);
    chk("rst_dout", 64'(c_dout != '0), 64'd0);
    rst = 1'b0;
    tick();
    // single-client vectors: misses, cache hits, writes and write invalidation
    for (int i = 0; i < 11; i++) begin
      req(v[i].c, v[i].wr, v[i].addr, v[i].din, v[i].m);
      tick();
      if (v[i].hit) begin
        chk($sformatf("v%0d_hit_ok", i), 64'(c_ok[v[i].c]), 64'd1);
        chk($sformatf("v%0d_hit_nobank", i), 64'(ba_rd | ba_wr), 64'd0);
      end else begin
        chk($sformatf("v%0d_req_lat", i), 64'(ba_rd | ba_wr), 64'd1);
        serve($sformatf("v%0d", i), v[i].ea, v[i].wr, v[i].din, v[i].m, 0, v[i].data);
        chk($sformatf("v%0d_ok", i), 64'(c_ok[v[i].c]), 64'd1);
      end
      if (!v[i].wr) chk($sformatf("v%0d_dout", i), c_dout[v[i].c*64 +: 64], v[i].data);
      c_cs[v[i].c] = 1'b0;
      tick();
      chk($sformatf("v%0d_ok_clr", i), 64'(c_ok[v[i].c]), 64'd0);
    end
    // delayed ack: request held stable, a late requester waits; requester that left gets a one-cycle ok
    req(0, 1'b0, 22'h000500, 16'h0, 2'b00);
    tick();
    req(1, 1'b0, 22'h000510, 16'h0, 2'b00);
    c_cs[0] = 1'b0;
    serve("dly", 22'h000500, 1'b0, 16'h0, 2'b00, 5, 64'h0123_4567_89ab_cdef);
    chk("dly_ok_pulse", 64'(c_ok[0]), 64'd1);
    chk("dly_dout", c_dout[63:0], 64'h0123_4567_89ab_cdef);
    tick();
    chk("dly_ok_gone", 64'(c_ok[0]), 64'd0);
    chk("dly_next_req", 64'({ba_rd, ba_addr}), 64'({1'b1, 22'h000510}));
    serve("dly1", 22'h000510, 1'b0, 16'h0, 2'b00, 0, 64'h1);
    chk("dly1_ok", 64'(c_ok[1]), 64'd1);
    c_cs[1] = 1'b0;
    tick();
    // reset in the middle of a burst
    req(3, 1'b0, 22'h000600, 16'h0, 2'b00);
    tick();
    chk("rd_req", 64'(ba_rd), 64'd1);
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ba_dok = 1'b1;
      ba_dst = k == 0;
      ba_dout = 16'h7000 + 16'(k);
      tick();
    end
    ba_dok = 1'b0;
    ba_dst = 1'b0;
    rst = 1'b1;
    c_cs = '0;
    #1;
    chk("rd_ok_clr", 64'(c_ok), 64'd0);
    chk("rd_rd_clr", 64'(ba_rd), 64'd0);
    chk("rd_dout_clr", 64'(c_dout != '0), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    req(2, 1'b0, 22'h3ffffe, 16'h0, 2'b00);
    tick();
    chk("rd_valid_clr", 64'(ba_rd), 64'd1);
    serve("rd2", 22'h3ffffc, 1'b0, 16'h0, 2'b00, 0, 64'hface_b00c_1234_5678);
    chk("rd2_dout", c_dout[2*64 +: 64], 64'hface_b00c_1234_5678);
    c_cs[2] = 1'b0;
    req(3, 1'b0, 22'h000700, 16'h0, 2'b00);
    tick();
    serve("rd3", 22'h000700, 1'b0, 16'h0, 2'b00, 0, 64'h3);
    c_cs[3] = 1'b0;
    tick();
    // simultaneous requests with pointer at 0, then at 2
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        req(1, 1'b0, 22'h000400, 16'h0, 2'b00);
        tick();
        serve("pre", 22'h000400, 1'b0, 16'h0, 2'b00, 0, 64'h4);
        c_cs[1] = 1'b0;
        tick();
      end
      for (int i = 0; i < N; i++) req(i, 1'b0, 22'(r == 0 ? 'h200 : 'h300) + 22'(i*16), 16'h0, 2'b00);
      tick();
      for (int k = 0; k < N; k++) begin
        int c;
        c = (2*r + k) % N;
        serve($sformatf("rr%0d_%0d", r, k), 22'(r == 0 ? 'h200 : 'h300) + 22'(c*16), 1'b0, 16'h0, 2'b00,
              0, 64'(c + 16*r));
        chk($sformatf("rr%0d_%0d_ok", r, k), 64'(c_ok[c]), 64'd1);
        chk($sformatf("rr%0d_%0d_dout", r, k), c_dout[c*64 +: 64], 64'(c + 16*r));
      end
      c_cs = '0;
      tick();
      chk($sformatf("rr%0d_ok_clr", r), 64'(c_ok), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
